// File: rtl/uart_pkg.sv
// Constants shared by the UART receive and transmit paths.
// Holds the FSM state encoding and the default frame geometry.
package uart_pkg;

  localparam int UART_DATA_BITS  = 8;
  localparam int UART_OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_START      = 3'd1;
  localparam logic [2:0] ST_DATA       = 3'd2;
  localparam logic [2:0] ST_STOP       = 3'd3;
  localparam logic [2:0] ST_BREAK_WAIT = 3'd4;

endpackage

// File: rtl/uart_rx_sipo_rx_sipo.sv
// Right-shift register that assembles an LSB-first serial word.
// The first bit shifted in ends up in bit 0 after DATA_BITS shifts.
module rx_sipo #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 shift_en,
  input  logic                 serial_in,
  output logic [DATA_BITS-1:0] data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      data <= '0;
    else if (shift_en)
      data <= {serial_in, data[DATA_BITS-1:1]};
  end

endmodule

// File: rtl/uart_rx_sipo.sv
// UART receiver: 2-flop synchroniser, oversampled start/bit/stop timing,
// SIPO word assembly and a valid/read handshake with framing and overrun flags.
module uart_rx_sipo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = UART_DATA_BITS,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 os_tick,
  input  logic                 rx_serial,
  input  logic                 rx_read,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 busy
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 sync1;
  logic                 rxs;
  logic [2:0]           state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 shift_en;
  logic                 stop_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      sync1 <= rx_serial;
      rxs   <= sync1;
    end
  end

  assign shift_en  = os_tick && (state == ST_DATA) && (tick_cnt == TICK_LAST);
  assign stop_done = os_tick && (state == ST_STOP) && (tick_cnt == TICK_LAST);
  assign busy      = (state != ST_IDLE);

  rx_sipo #(.DATA_BITS(DATA_BITS)) u_sipo (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (shift_en),
    .serial_in (rxs),
    .data      (shreg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          // Start detection runs every clock, not only on os_tick.
          if (!rxs) begin
            state    <= ST_START;
            tick_cnt <= '0;
          end
        end
        ST_START: begin
          if (os_tick) begin
            if (tick_cnt == TICK_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rxs ? ST_IDLE : ST_DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_DATA: begin
          if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              if (bit_cnt == BIT_LAST) begin
                bit_cnt <= '0;
                state   <= ST_STOP;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_STOP: begin
          if (os_tick) begin
            if (tick_cnt == TICK_LAST) begin
              tick_cnt <= '0;
              state    <= rxs ? ST_IDLE : ST_BREAK_WAIT;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        ST_BREAK_WAIT: begin
          if (rxs)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A completing word takes priority over a same-cycle read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else if (stop_done) begin
      rx_data     <= shreg;
      rx_valid    <= 1'b1;
      frame_err   <= ~rxs;
      overrun_err <= overrun_err | (rx_valid & ~rx_read);
    end else if (rx_read && rx_valid) begin
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end
  end

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
- UART receive path, 8N1 framing by default, LSB first; the receive-side counterpart of the transmit parallel-in/serial-out shifter.
- Synchronises the serial line and detects the start bit with 16x oversampling.
- Samples each bit at mid-period, assembles the word serially-in/parallel-out, and presents it with a valid/read handshake plus framing and overrun flags.
- Sits between the pad-side rx line and the host/register interface; shares the baud tick generator with the transmitter.

Parameters:
- DATA_BITS, 8, number of data bits per frame.
- OVERSAMPLE, 16, os_tick pulses per bit period; must be even and ≥4.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- os_tick  input  1  single-cycle enable at OVERSAMPLE x baud rate
- rx_serial  input  1  asynchronous serial line; idles high
- rx_read  input  1  single-cycle pulse; consumer has taken rx_data
- rx_data  output  DATA_BITS  last received word
- rx_valid  output  1  rx_data holds an unread word
- frame_err  output  1  stop bit of the current rx_data word sampled 0
- overrun_err  output  1  a word was overwritten before being read; sticky
- busy  output  1  high whenever state is not IDLE

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-high.
  - Reset values: rx_data=0, rx_valid=0, frame_err=0, overrun_err=0, busy=0, state=IDLE.
  - Internal shift register and counters reset to 0; both synchroniser flops reset to 1.
  - Reset mid-frame abandons the frame with no output update.
- Input synchronisation: rx_serial passes through a 2-flop synchroniser; rxs denotes the synchronised value.
- All state and counter advances occur only on clk edges where os_tick=1. The only exceptions are the IDLE start-edge detection and the rx_read handling.
- IDLE:
  - When rxs=0, go to START with tick_cnt=0.
- START:
  - tick_cnt increments on each os_tick.
  - At tick_cnt=OVERSAMPLE/2-1 (mid start bit), sample rxs.
  - rxs=0: go to DATA with tick_cnt=0 and bit_cnt=0.
  - rxs=1: treat as a glitch and return to IDLE with no output change.
- DATA:
  - tick_cnt counts 0..OVERSAMPLE-1. At OVERSAMPLE-1, sample rxs (mid-bit) and reset tick_cnt.
  - On each sample, shift right: shreg <= {rxs, shreg[DATA_BITS-1:1]}. After DATA_BITS shifts, the first received bit sits in bit 0.
  - bit_cnt increments per sample. When bit_cnt reaches DATA_BITS-1 and that bit is sampled, go to STOP.
- STOP:
  - Sample rxs at tick_cnt=OVERSAMPLE-1. On that edge:
    - rx_data<=shreg
    - rx_valid<=1
    - frame_err<=~rxs
    - overrun_err<=overrun_err | (rx_valid & ~rx_read)
  - Next state: IDLE if rxs=1; BREAK_WAIT if rxs=0.
- BREAK_WAIT:
  - Remain until rxs=1, then go to IDLE. A held-low line (break) does not re-trigger a start.
- Latency: outputs update on the clk edge of the stop-bit sample; visible the following cycle. This is about 9.5 bit periods plus 2 synchroniser cycles after the start falling edge.
- rx_read handling:
  - rx_read clears rx_valid, frame_err and overrun_err on the next edge.
  - rx_read while rx_valid=0 has no effect.
- Simultaneous rx_read and word completion: the new word wins. rx_valid stays 1, frame_err reflects the new word, and overrun_err is not set by this event.
- Counter widths: tick_cnt is clog2(OVERSAMPLE) bits; bit_cnt is clog2(DATA_BITS) bits. Neither counter wraps outside its terminal compare.
- os_tick low for long stretches simply stalls the FSM. rxs is not sampled between ticks except in IDLE and BREAK_WAIT.

Decomposition:
- Shared package/include uart_pkg holds:
  - state encoding: IDLE=0, START=1, DATA=2, STOP=3, BREAK_WAIT=4
  - default DATA_BITS and OVERSAMPLE constants, shared with the transmitter
- One natural sub-module, rx_sipo: DATA_BITS-wide right-shift register with shift enable and serial-in, reset to 0. FSM, counters, synchroniser and handshake stay in the top.

Test Plan:
- Clean frame 0xA5 at OVERSAMPLE=16 (line 0,1,0,1,0,0,1,0,1,1) -> rx_data=0xA5, rx_valid=1, frame_err=0, busy low afterward; rx_read pulse -> rx_valid=0.
- Glitch: rx_serial low for 4 os_ticks then high -> back to IDLE, rx_valid stays 0, busy drops after the START sample.
- Framing error: 0x3C with stop bit 0, line held low 3 more bit times -> rx_data=0x3C, rx_valid=1, frame_err=1, state BREAK_WAIT until line high; no second word.
- Overrun: frames 0x11 then 0x22 with no rx_read -> rx_data=0x22, rx_valid=1, overrun_err=1; rx_read clears all three flags.
- rx_read on the same clk as the 0x77 stop sample while 0x66 is pending -> rx_data=0x77, rx_valid=1, overrun_err=0.
- Reset asserted during bit 4 of 0xF0 -> all outputs 0, state IDLE; a following 0x0F frame is received correctly.
